// File: rtl/pwm_meas_pkg.sv
// Shared types and default parameters for the PWM period/high-time meter.
package pwm_meas_pkg;

  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefSyncStages = 2;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by rise/fall edge detection.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      delay_q <= sync;
    end
  end

  assign rise = sync & ~delay_q;
  assign fall = ~sync & delay_q;

endmodule

// File: rtl/pwm_meas.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Optional stuck-input detection is enabled by defining PWM_MEAS_STUCK_DET_EN.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             overrun
`ifdef PWM_MEAS_STUCK_DET_EN
  ,
  output logic             stuck
`endif
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic rise, fall;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .rise (rise),
    .fall (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_meas_q, high_meas_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             publish, handshake, sat;
`ifdef PWM_MEAS_STUCK_DET_EN
  logic             stuck_q, stuck_d;
`endif

  assign handshake = valid_q & meas_ready;
  assign sat       = (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    high_meas_d = high_meas_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    publish     = 1'b0;
`ifdef PWM_MEAS_STUCK_DET_EN
    stuck_d     = stuck_q;
`endif

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (!sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    unique case (state_q)
      StIdle: if (rise) state_d = StHigh;
      StHigh: begin
        if (fall) begin
          state_d     = StLow;
          high_meas_d = cnt_q;
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
          publish = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef PWM_MEAS_STUCK_DET_EN
    // A saturated count with no edge means the input has stopped toggling.
    if (rise) begin
      stuck_d = 1'b0;
    end else if (sat && ((state_q == StHigh && !fall) || state_q == StLow)) begin
      state_d = StIdle;
      stuck_d = 1'b1;
    end
`endif

    // A pending result is never overwritten unless it is accepted this very cycle.
    if (publish) begin
      if (!valid_q || handshake) begin
        valid_d  = 1'b1;
        period_d = cnt_q;
        high_d   = high_meas_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    if (clr) begin
      state_d     = StIdle;
      cnt_d       = '0;
      high_meas_d = '0;
      period_d    = '0;
      high_d      = '0;
      valid_d     = 1'b0;
      overrun_d   = 1'b0;
`ifdef PWM_MEAS_STUCK_DET_EN
      stuck_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      high_meas_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PWM_MEAS_STUCK_DET_EN
      stuck_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_meas_q <= high_meas_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef PWM_MEAS_STUCK_DET_EN
      stuck_q     <= stuck_d;
`endif
    end
  end

  assign meas_valid = valid_q;
  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign overrun    = overrun_q;
`ifdef PWM_MEAS_STUCK_DET_EN
  assign stuck      = stuck_q;
`endif

endmodule
